// File: rtl/rowbias_gen.sv
// Per-row bias feeder: hands out one-hot hint values in LFSR order,
// never repeating a value within a row until the pool refills or restarts.
module rowbias_gen #(
    parameter int                 GRID_LEN = 9,
    parameter int                 LFSR_W   = 16,
    parameter logic [LFSR_W-1:0]  SEED     = LFSR_W'(16'hACE1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                updaterowbias,
    input  logic [GRID_LEN:0]   rqindex,
    output logic [GRID_LEN-1:0] rowbias,
    output logic                biasvalid,
    output logic                busy,
    output logic [GRID_LEN-1:0] usedmask
);

    localparam int CW = (GRID_LEN > 1) ? $clog2(GRID_LEN) : 1;

    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(16'hB400);
    localparam logic [LFSR_W-1:0] SEED_EFF =
        (SEED == '0) ? LFSR_W'(1) : SEED;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PICK  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    localparam logic [GRID_LEN:0]   RQ_ONE   = (GRID_LEN+1)'(1);
    localparam logic [GRID_LEN-1:0] BIAS_ONE = GRID_LEN'(1);
    localparam logic [CW-1:0]       CAND_MAX = CW'(GRID_LEN - 1);
    localparam logic [7:0]          MOD_DIV  = 8'(GRID_LEN);

    logic [1:0]          state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CW-1:0]       cand_q, cand_d;
    logic [GRID_LEN-1:0] rowbias_q, rowbias_d;
    logic [GRID_LEN-1:0] used_q, used_d;

    logic [7:0]          lfsr_lo;
    logic [7:0]          lfsr_mod;
    logic [CW-1:0]       cand_start;
    logic                req_onehot;
    logic                req_accept;

    // Galois right-shift form; runs regardless of FSM state
    assign lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]}
                  ^ (lfsr_q[0] ? TAPS : '0);

    assign lfsr_lo    = lfsr_q[7:0];
    assign lfsr_mod   = lfsr_lo % MOD_DIV;
    assign cand_start = lfsr_mod[CW-1:0];

    assign req_onehot = (rqindex != '0)
                      && ((rqindex & (rqindex - RQ_ONE)) == '0);
    assign req_accept = updaterowbias && req_onehot;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        rowbias_d = rowbias_q;
        used_d    = used_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_accept) begin
                    if (rqindex[GRID_LEN]) begin
                        used_d = '0;
                    end else begin
                        cand_d  = cand_start;
                        if (&used_q) used_d = '0;
                        state_d = S_PICK;
                    end
                end
            end
            S_PICK: begin
                // Pool always has a free slot here, so the scan terminates
                if (!used_q[cand_q]) begin
                    rowbias_d      = BIAS_ONE << cand_q;
                    used_d[cand_q] = 1'b1;
                    state_d        = S_VALID;
                end else begin
                    cand_d = (cand_q == CAND_MAX) ? '0
                                                  : cand_q + CW'(1);
                end
            end
            S_VALID: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_EFF;
            cand_q    <= '0;
            rowbias_q <= '0;
            used_q    <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cand_q    <= cand_d;
            rowbias_q <= rowbias_d;
            used_q    <= used_d;
        end
    end

    assign rowbias   = rowbias_q;
    assign usedmask  = used_q;
    assign biasvalid = (state_q == S_VALID);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rowbias_gen.sv
// Scoreboard bench for rowbias_gen: stimulus pushes predicted picks,
// a negedge monitor pops and compares on each biasvalid pulse.
module tb_rowbias_gen;

    localparam int G = 9;

    typedef struct {
        logic [G-1:0] rb;
        logic [G-1:0] um;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         updaterowbias = 1'b0;
    logic [G:0]   rqindex = '0;
    logic [G-1:0] rowbias;
    logic         biasvalid;
    logic         busy;
    logic [G-1:0] usedmask;

    exp_t         sb[$];
    logic [15:0]  m_lfsr;
    logic [G-1:0] exp_used;
    int           pass_cnt = 0;
    int           tot_cnt  = 0;
    int           npulse   = 0;

    rowbias_gen #(.GRID_LEN(G), .LFSR_W(16), .SEED(16'hACE1)) dut (
        .clock        (clock),
        .reset        (reset),
        .updaterowbias(updaterowbias),
        .rqindex      (rqindex),
        .rowbias      (rowbias),
        .biasvalid    (biasvalid),
        .busy         (busy),
        .usedmask     (usedmask)
    );

    always #5 clock = ~clock;

    // Reference LFSR: 16-bit Galois, taps B400, free-running
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [G-1:0] pick(input logic [15:0] l,
                                          input logic [G-1:0] used);
        int s;
        logic [G-1:0] r;
        s = int'(l[7:0]) % G;
        r = '0;
        for (int i = 0; i < G; i++) begin
            int idx;
            idx = (s + i) % G;
            if (r == '0 && !used[idx]) r[idx] = 1'b1;
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset && biasvalid) begin
            npulse++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rowbias", 16'(rowbias), 16'(e.rb));
                chk("usedmask", 16'(usedmask), 16'(e.um));
            end
        end
    end

    task automatic tile_req();
        logic [G-1:0] p;
        @(negedge clock);
        if (&exp_used) exp_used = '0;
        p = pick(m_lfsr, exp_used);
        exp_used = exp_used | p;
        sb.push_back('{rb: p, um: exp_used});
        updaterowbias = 1'b1;
        rqindex = 10'b0000000001;
        @(negedge clock);
        updaterowbias = 1'b0;
        rqindex = '0;
    endtask

    task automatic raw_req(input logic [G:0] rq);
        @(negedge clock);
        updaterowbias = 1'b1;
        rqindex = rq;
        @(negedge clock);
        updaterowbias = 1'b0;
        rqindex = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (n >= 30) begin
            chk("timeout", 16'd1, 16'd0);
            sb.delete();
        end
    endtask

    task automatic restart();
        raw_req(10'b1000000000);
        exp_used = '0;
    endtask

    initial begin
        logic [G-1:0] acc;
        logic [G-1:0] rb_s;
        logic [G-1:0] um_s;
        logic [G-1:0] free;
        int p0;
        exp_used = '0;

        repeat (2) @(negedge clock);
        chk("rst_rowbias", 16'(rowbias), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_usedmask", 16'(usedmask), 16'h0);
        reset = 1'b1;

        // Reset asserted while PICK is in progress
        tile_req();
        chk("midpick_busy", 16'(busy), 16'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_rowbias", 16'(rowbias), 16'h0);
        chk("async_biasvalid", 16'(biasvalid), 16'h0);
        chk("async_busy", 16'(busy), 16'h0);
        chk("async_usedmask", 16'(usedmask), 16'h0);
        sb.delete();
        exp_used = '0;
        @(negedge clock);
        reset = 1'b1;

        // Nine requests exhaust the pool
        restart();
        acc = '0;
        for (int i = 0; i < G; i++) begin
            if (i == G - 1) free = ~usedmask;
            tile_req();
            wait_idle();
            acc = acc | rowbias;
            if (i == G - 1) chk("last_free", 16'(rowbias), 16'(free));
        end
        chk("or_all", 16'(acc), 16'h1FF);
        chk("full_mask", 16'(usedmask), 16'h1FF);

        // Tenth request refills the pool
        tile_req();
        chk("refill_zero", 16'(usedmask), 16'h0);
        wait_idle();
        chk("refill_onehot", 16'(usedmask), 16'(rowbias));

        // Malformed requests are ignored
        rb_s = rowbias;
        um_s = usedmask;
        raw_req(10'b0000000011);
        chk("multihot_busy", 16'(busy), 16'h0);
        raw_req(10'b0000000000);
        chk("zero_busy", 16'(busy), 16'h0);
        chk("ignored_rowbias", 16'(rowbias), 16'(rb_s));
        chk("ignored_usedmask", 16'(usedmask), 16'(um_s));

        // Request during busy is dropped
        p0 = npulse;
        tile_req();
        raw_req(10'b0000000010);
        wait_idle();
        repeat (4) @(negedge clock);
        chk("drop_pulses", 16'(npulse - p0), 16'd1);

        // Restart with a partial pool
        tile_req();
        wait_idle();
        rb_s = rowbias;
        chk("partial_nonzero", 16'(usedmask != '0), 16'h1);
        restart();
        chk("restart_mask", 16'(usedmask), 16'h0);
        chk("restart_valid", 16'(biasvalid), 16'h0);
        chk("restart_busy", 16'(busy), 16'h0);
        chk("restart_rowbias", 16'(rowbias), 16'(rb_s));
        repeat (3) @(negedge clock);
        chk("restart_nopulse", 16'(sb.size()), 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/rowbias_gen.md
Name: rowbias_gen

Overview:
- Upstream feeder for the tile chain: supplies each tile's `rowbias`, a one-hot "try this value first" hint, on request.
- Draws from a per-row pool of unused values in pseudo-random order, using a free-running LFSR.
- Guarantees that, within one row, no value is handed out twice until the pool is exhausted or the row is restarted.
- One instance per row; its outputs fan out to the tiles of that row.

Parameters:
- GRID_LEN, default `GRID_LEN (9 at order 3): number of values per row; width of the one-hot value vectors.
- LFSR_W, default 16: LFSR width.
- SEED, default 16'hACE1: LFSR reset value; a value of 0 is replaced by 1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- updaterowbias  in  1  request strobe from a tile, sampled on the clock edge.
- rqindex  in  GRID_LEN+1  one-hot requester select. Bits [GRID_LEN-1:0] select the requesting tile; bit GRID_LEN means "row restart".
- rowbias  out  GRID_LEN  one-hot bias value. Held stable until the next pick.
- biasvalid  out  1  one-cycle pulse: `rowbias` was just updated.
- busy  out  1  high while in PICK or VALID.
- usedmask  out  GRID_LEN  values already handed out this row (debug/observe).

Behaviour:
- Reset asserted (low), asynchronously:
  - state=IDLE, lfsr=SEED (or 1 if SEED=0).
  - rowbias=0, biasvalid=0, busy=0, usedmask=0.
  - Reset asserted mid-PICK aborts the pick; no partial update survives.
- LFSR: 16-bit Galois, taps 16'hB400. Advances every clock while out of reset, independent of state.
- IDLE:
  - A request is accepted only when updaterowbias=1 and rqindex is exactly one-hot.
  - rqindex[GRID_LEN]=1: usedmask<=0. No bias is produced, biasvalid stays 0, state stays IDLE.
  - Tile bit set:
    - cand <= lfsr[7:0] mod GRID_LEN.
    - If usedmask is all ones, usedmask<=0 (pool refill) in the same edge.
    - Go to PICK.
  - rqindex zero or multi-hot: request ignored, no state change.
- PICK (busy=1):
  - Each cycle examine cand.
  - usedmask[cand]=0: rowbias<=1<<cand, usedmask[cand]<=1, go to VALID.
  - Otherwise cand<=(cand==GRID_LEN-1)?0:cand+1 (wrap-around).
  - Bounded: at most GRID_LEN cycles in PICK, because at least one bit is free on entry.
- VALID: biasvalid=1 for exactly one cycle, busy=1, then return to IDLE.
- Latency: request edge to biasvalid high is 2..GRID_LEN+1 clocks.
- Requests arriving while busy=1 are dropped, not queued. Tiles retry after observing busy=0.
- Restart and a tile request in the same cycle cannot occur, because multi-hot rqindex is ignored.
- Invariants:
  - rowbias is always 0 or one-hot.
  - After reset, popcount(usedmask) equals the number of bias pulses since the last restart or refill (mod GRID_LEN, with refill).
- Width rules:
  - cand is $clog2(GRID_LEN) bits.
  - The mod is computed combinationally on an 8-bit operand; a constant-divisor reduction is acceptable.

Test Plan:
1. Reset low for 2 cycles, then release; assert reset again mid-PICK → rowbias=0, biasvalid=0, busy=0, usedmask=0 immediately, without waiting for a clock edge.
2. Restart, then 9 requests with rqindex=10'b0000000001, each issued after busy falls → 9 biasvalid pulses, all rowbias distinct one-hot, OR of them = 9'h1FF, final usedmask=9'h1FF.
3. Continue to a 10th request → refill: usedmask passes through 0, ends one-hot equal to the new rowbias, biasvalid pulses once.
4. With usedmask=9'h1EF (only bit 4 free), request → rowbias=9'h010 after ≤10 clocks, usedmask=9'h1FF.
5. Request with rqindex=10'b0000000011, then with 10'b0 → no state change, busy stays 0, rowbias unchanged; request asserted during busy=1 → dropped, exactly one biasvalid pulse results.
6. rqindex=10'b1000000000 with usedmask=9'h0F3 → usedmask=0 next edge, biasvalid stays 0, rowbias unchanged.
